mem_port_arbiter: RTL

Single-port memory arbiter and stall controller for the 5-stage pipeline. It shares one unified instruction/data memory between the IF stage's fetch and the MEM stage's load/store, which it receives from the EX/MEM pipeline register outputs. It sequences each access over a fixed number of wait states and drives a global `stall` that freezes the PC and all pipeline registers until both the pending fetch and the pending data access have completed.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter_wait_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } state_e;

  localparam int unsigned MAX_WAIT_STATES = 15;

  // Counter width able to hold 0..ws, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned ws);
    int unsigned w;
    w = $clog2(ws + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] read_data2_mem;
  logic [31:0] mem_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        stall;

  modport slave (
    input  if_req, if_addr, mem_read_mem, mem_write_mem,
           alu_result_mem, read_data2_mem, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
           if_valid, if_rdata, d_valid, d_rdata, stall
  );

  modport master (
    output if_req, if_addr, mem_read_mem, mem_write_mem,
           alu_result_mem, read_data2_mem, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
           if_valid, if_rdata, d_valid, d_rdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Wait-state counter: flags the final cycle of a memory access.
module wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned CNT_W       = cnt_width(WAIT_STATES)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Count access cycles; clear has priority over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_done = (r_cnt == CNT_W'(WAIT_STATES));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetch and MEM load/store, stalling
// the pipeline until every pending access of the current cycle is served.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WAIT_STATES);

  state_e      r_state;
  logic        r_we;
  logic        r_d_done;
  logic        r_if_done;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_d_rdata;
  logic [31:0] r_if_rdata;

  logic w_d_req;
  logic w_d_pend;
  logic w_if_pend;
  logic w_stall;
  logic w_busy;
  logic w_idle;
  logic w_cnt_done;
  logic w_d_complete;
  logic w_if_complete;

  assign w_d_req       = bus.mem_read_mem | bus.mem_write_mem;
  assign w_d_pend      = w_d_req & ~r_d_done;
  assign w_if_pend     = bus.if_req & ~r_if_done;
  assign w_stall       = w_d_pend | w_if_pend;
  assign w_busy        = (r_state != IDLE);
  assign w_idle        = ~w_busy;
  assign w_d_complete  = (r_state == D_BUSY) & w_cnt_done;
  assign w_if_complete = (r_state == I_BUSY) & w_cnt_done;

  wait_counter #(
    .WAIT_STATES (WAIT_STATES),
    .CNT_W       (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_idle),
    .i_enable (w_busy),
    .o_done   (w_cnt_done)
  );

  // Arbitration FSM: data first (older instruction), then fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_d_pend) begin
            r_state <= D_BUSY;
            r_addr  <= bus.alu_result_mem;
            r_wdata <= bus.read_data2_mem;
            r_we    <= bus.mem_write_mem;
          end else if (w_if_pend) begin
            r_state <= I_BUSY;
            r_addr  <= bus.if_addr;
            r_we    <= 1'b0;
          end
        end
        D_BUSY, I_BUSY: begin
          if (w_cnt_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Completion flags and returned data; flags drop when the pipeline advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_done   <= 1'b0;
      r_if_done  <= 1'b0;
      r_d_rdata  <= '0;
      r_if_rdata <= '0;
    end else if (!w_stall) begin
      r_d_done  <= 1'b0;
      r_if_done <= 1'b0;
    end else begin
      if (w_d_complete) begin
        r_d_done <= 1'b1;
        if (!r_we) r_d_rdata <= bus.mem_rdata;
      end
      if (w_if_complete) begin
        r_if_done  <= 1'b1;
        r_if_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = w_busy;
  assign bus.mem_we    = w_d_complete & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.d_valid   = r_d_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_valid  = r_if_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.stall     = w_stall;

endmodule
